// File: rtl/stream_fifo_pkt.sv
// Single-clock valid/ready stream FIFO with show-ahead output, fill level, almost flags,
// synchronous flush and an optional packet mode that holds output until a whole packet is stored.
module stream_fifo_pkt #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_LEN      = 16,
    parameter int PACKET_MODE   = 0,
    parameter int AFULL_THRESH  = FIFO_LEN - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int LVL_WIDTH     = $clog2(FIFO_LEN + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [LVL_WIDTH-1:0]  level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [LVL_WIDTH-1:0]  pkt_count_o
);

    localparam int PTR_W = (FIFO_LEN > 2) ? $clog2(FIFO_LEN) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR   = PTR_W'(FIFO_LEN - 1);
    localparam logic [LVL_WIDTH-1:0] FULL_LVL   = LVL_WIDTH'(FIFO_LEN);
    localparam logic [LVL_WIDTH-1:0] AFULL_LVL  = LVL_WIDTH'(AFULL_THRESH);
    localparam logic [LVL_WIDTH-1:0] AEMPTY_LVL = LVL_WIDTH'(AEMPTY_THRESH);

    // Each entry carries the payload with the last flag in the top bit.
    logic [DATA_WIDTH:0]    mem_reg [FIFO_LEN];
    logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [LVL_WIDTH-1:0]   level_reg, level_next;
    logic [LVL_WIDTH-1:0]   pkt_count_reg, pkt_count_next;
    logic [DATA_WIDTH:0]    head_entry;
    logic                   clear;
    logic                   wr_en;
    logic                   rd_en;
    logic                   presentable;

    assign clear = ARESET | flush_i;

    // Asynchronous read at the read pointer gives show-ahead with one cycle write-to-read latency.
    assign head_entry = mem_reg[rd_ptr_reg];
    assign data_o     = head_entry[DATA_WIDTH-1:0];
    assign last_o     = head_entry[DATA_WIDTH];

    // Full term releases packets longer than the FIFO so they stream instead of deadlocking.
    always_comb begin
        presentable = 1'b1;
        if (PACKET_MODE != 0) begin
            presentable = (pkt_count_reg != '0) | (level_reg == FULL_LVL);
        end
    end

    assign ready_o = ~clear & (level_reg < FULL_LVL);
    assign valid_o = ~clear & (level_reg != '0) & presentable;

    assign wr_en = valid_i & ready_o;
    assign rd_en = valid_o & ready_i;

    assign level_o        = ARESET ? '0 : level_reg;
    assign pkt_count_o    = ARESET ? '0 : pkt_count_reg;
    assign almost_full_o  = (level_o >= AFULL_LVL);
    assign almost_empty_o = (level_o <= AEMPTY_LVL);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        if (wr_en) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (rd_en) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({wr_en, rd_en})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        pkt_count_next = pkt_count_reg;
        case ({wr_en & last_i, rd_en & last_o})
            2'b10:   pkt_count_next = pkt_count_reg + 1'b1;
            2'b01:   pkt_count_next = pkt_count_reg - 1'b1;
            default: pkt_count_next = pkt_count_reg;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (clear) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            pkt_count_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            pkt_count_reg <= pkt_count_next;
        end
    end

    // Storage is never cleared; wr_en is already gated off during reset and flush.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= {last_i, data_i};
        end
    end

endmodule

// File: tb/tb_stream_fifo_pkt.sv
// Directed bench: a vector table for the 5-deep streaming FIFO plus hand sequences for
// packet mode (8 and 4 deep), flush and mid-stream reset.
module tb_stream_fifo_pkt;

    logic        clk;
    logic        ARESET;
    logic        flush_i;
    logic [31:0] data_i;
    logic        last_i;
    logic        valid_i;
    logic        ready_i;

    logic        a_ready, a_last, a_valid, a_af, a_ae;
    logic [31:0] a_data;
    logic [2:0]  a_level, a_pkt;
    logic        b_ready, b_last, b_valid, b_af, b_ae;
    logic [31:0] b_data;
    logic [3:0]  b_level, b_pkt;
    logic        c_ready, c_last, c_valid, c_af, c_ae;
    logic [31:0] c_data;
    logic [2:0]  c_level, c_pkt;

    int n_vec;
    int n_miss;

    stream_fifo_pkt #(.DATA_WIDTH(32), .FIFO_LEN(5), .PACKET_MODE(0)) dut_a (
        .ACLK(clk), .ARESET(ARESET), .flush_i(flush_i), .data_i(data_i), .last_i(last_i),
        .valid_i(valid_i), .ready_o(a_ready), .data_o(a_data), .last_o(a_last),
        .valid_o(a_valid), .ready_i(ready_i), .level_o(a_level), .almost_full_o(a_af),
        .almost_empty_o(a_ae), .pkt_count_o(a_pkt)
    );

    stream_fifo_pkt #(.DATA_WIDTH(32), .FIFO_LEN(8), .PACKET_MODE(1)) dut_b (
        .ACLK(clk), .ARESET(ARESET), .flush_i(flush_i), .data_i(data_i), .last_i(last_i),
        .valid_i(valid_i), .ready_o(b_ready), .data_o(b_data), .last_o(b_last),
        .valid_o(b_valid), .ready_i(ready_i), .level_o(b_level), .almost_full_o(b_af),
        .almost_empty_o(b_ae), .pkt_count_o(b_pkt)
    );

    stream_fifo_pkt #(.DATA_WIDTH(32), .FIFO_LEN(4), .PACKET_MODE(1)) dut_c (
        .ACLK(clk), .ARESET(ARESET), .flush_i(flush_i), .data_i(data_i), .last_i(last_i),
        .valid_i(valid_i), .ready_o(c_ready), .data_o(c_data), .last_o(c_last),
        .valid_o(c_valid), .ready_i(ready_i), .level_o(c_level), .almost_full_o(c_af),
        .almost_empty_o(c_ae), .pkt_count_o(c_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        vin;
        logic [31:0] din;
        logic        lin;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic        erdy;
        int          elvl;
        int          epkt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic vin, input logic [31:0] din, input logic lin,
                                input logic rdy, input logic ev, input logic [31:0] ed,
                                input logic el, input logic erdy, input int elvl, input int epkt);
        vec_t v;
        v.flush = 1'b0; v.vin = vin; v.din = din; v.lin = lin; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.erdy = erdy; v.elvl = elvl; v.epkt = epkt;
        vecs.push_back(v);
    endfunction

    // Inputs change on the falling edge; outputs are observed 1 time unit later.
    task automatic drive(input logic rst, input logic f, input logic v, input logic [31:0] d,
                         input logic l, input logic r);
        @(negedge clk);
        ARESET = rst; flush_i = f; valid_i = v; data_i = d; last_i = l; ready_i = r;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        ARESET = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b0;

        // Table for the 5-deep streaming instance: fill/drain, steady-state wrap, full with read.
        add(1, 32'h10, 0, 0,  0, 32'h00, 0, 1, 0, 0);
        add(1, 32'h11, 0, 0,  1, 32'h10, 0, 1, 1, 0);
        add(1, 32'h12, 1, 0,  1, 32'h10, 0, 1, 2, 0);
        add(1, 32'h13, 0, 0,  1, 32'h10, 0, 1, 3, 1);
        add(1, 32'h14, 1, 0,  1, 32'h10, 0, 1, 4, 1);
        add(0, 32'h00, 0, 0,  1, 32'h10, 0, 0, 5, 2);
        add(0, 32'h00, 0, 1,  1, 32'h10, 0, 0, 5, 2);
        add(0, 32'h00, 0, 1,  1, 32'h11, 0, 1, 4, 2);
        add(0, 32'h00, 0, 1,  1, 32'h12, 1, 1, 3, 2);
        add(0, 32'h00, 0, 1,  1, 32'h13, 0, 1, 2, 1);
        add(0, 32'h00, 0, 1,  1, 32'h14, 1, 1, 1, 1);
        add(0, 32'h00, 0, 0,  0, 32'h00, 0, 1, 0, 0);
        add(1, 32'h20, 0, 0,  0, 32'h00, 0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            add(1, 32'h20 + 32'(k), 0, 1,  1, 32'h20 + 32'(k - 1), 0, 1, 1, 0);
        end
        add(0, 32'h00, 0, 1,  1, 32'h2C, 0, 1, 1, 0);
        add(0, 32'h00, 0, 0,  0, 32'h00, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            add(1, 32'h30 + 32'(k), 0, 0,  (k > 0), 32'h30, 0, 1, k, 0);
        end
        add(1, 32'h35, 0, 1,  1, 32'h30, 0, 0, 5, 0);
        add(1, 32'h35, 0, 0,  1, 32'h31, 0, 1, 4, 0);
        add(0, 32'h00, 0, 1,  1, 32'h31, 0, 0, 5, 0);
        add(0, 32'h00, 0, 1,  1, 32'h32, 0, 1, 4, 0);
        add(0, 32'h00, 0, 1,  1, 32'h33, 0, 1, 3, 0);
        add(0, 32'h00, 0, 1,  1, 32'h34, 0, 1, 2, 0);
        add(0, 32'h00, 0, 1,  1, 32'h35, 0, 1, 1, 0);
        add(0, 32'h00, 0, 0,  0, 32'h00, 0, 1, 0, 0);

        // Reset state.
        drive(1, 0, 1, 32'hAA, 0, 1);
        drive(1, 0, 1, 32'hAA, 0, 1);
        chk("rst ready", 32'(a_ready), 32'd0);
        chk("rst valid", 32'(a_valid), 32'd0);
        chk("rst level", 32'(a_level), 32'd0);
        chk("rst aempty", 32'(a_ae), 32'd1);
        chk("rst afull", 32'(a_af), 32'd0);
        chk("rst pkt", 32'(a_pkt), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].flush, vecs[i].vin, vecs[i].din, vecs[i].lin, vecs[i].rdy);
            chk($sformatf("v%0d valid", i), 32'(a_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d ready", i), 32'(a_ready), 32'(vecs[i].erdy));
            chk($sformatf("v%0d level", i), 32'(a_level), 32'(vecs[i].elvl));
            chk($sformatf("v%0d pkt", i), 32'(a_pkt), 32'(vecs[i].epkt));
            chk($sformatf("v%0d afull", i), 32'(a_af), 32'(vecs[i].elvl >= 3));
            chk($sformatf("v%0d aempty", i), 32'(a_ae), 32'(vecs[i].elvl <= 2));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d data", i), a_data, vecs[i].ed);
                chk($sformatf("v%0d last", i), 32'(a_last), 32'(vecs[i].el));
            end
        end

        // Packet mode, 8 deep: output held until the last beat is stored.
        drive(0, 1, 0, 32'h0, 0, 0);
        drive(0, 0, 1, 32'h40, 0, 1);
        chk("pk8 b1 valid", 32'(b_valid), 32'd0);
        chk("pk8 b1 ready", 32'(b_ready), 32'd1);
        drive(0, 0, 1, 32'h41, 0, 1);
        chk("pk8 b2 valid", 32'(b_valid), 32'd0);
        chk("pk8 b2 level", 32'(b_level), 32'd1);
        drive(0, 0, 1, 32'h42, 1, 1);
        chk("pk8 b3 valid", 32'(b_valid), 32'd0);
        chk("pk8 b3 pkt", 32'(b_pkt), 32'd0);
        drive(0, 0, 0, 32'h0, 0, 0);
        chk("pk8 done valid", 32'(b_valid), 32'd1);
        chk("pk8 done pkt", 32'(b_pkt), 32'd1);
        chk("pk8 done level", 32'(b_level), 32'd3);
        chk("pk8 hold data", b_data, 32'h40);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 32'h0, 0, 1);
            chk($sformatf("pk8 rd%0d valid", k), 32'(b_valid), 32'd1);
            chk($sformatf("pk8 rd%0d data", k), b_data, 32'h40 + 32'(k));
            chk($sformatf("pk8 rd%0d last", k), 32'(b_last), 32'(k == 2));
        end
        drive(0, 0, 0, 32'h0, 0, 0);
        chk("pk8 end valid", 32'(b_valid), 32'd0);
        chk("pk8 end pkt", 32'(b_pkt), 32'd0);
        chk("pk8 end level", 32'(b_level), 32'd0);

        // Packet mode, 4 deep: 6-beat packet released by the full condition.
        drive(0, 1, 0, 32'h0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 32'h50 + 32'(k), 0, 0);
            chk($sformatf("pk4 w%0d level", k), 32'(c_level), 32'(k));
            chk($sformatf("pk4 w%0d valid", k), 32'(c_valid), 32'd0);
        end
        drive(0, 0, 1, 32'h54, 0, 0);
        chk("pk4 full level", 32'(c_level), 32'd4);
        chk("pk4 full valid", 32'(c_valid), 32'd1);
        chk("pk4 full pkt", 32'(c_pkt), 32'd0);
        chk("pk4 full ready", 32'(c_ready), 32'd0);
        chk("pk4 full data", c_data, 32'h50);
        drive(0, 0, 1, 32'h54, 0, 1);
        chk("pk4 s0 data", c_data, 32'h50);
        chk("pk4 s0 ready", 32'(c_ready), 32'd0);
        drive(0, 0, 1, 32'h54, 0, 1);
        chk("pk4 s1 valid", 32'(c_valid), 32'd0);
        chk("pk4 s1 ready", 32'(c_ready), 32'd1);
        drive(0, 0, 1, 32'h55, 1, 1);
        chk("pk4 s2 valid", 32'(c_valid), 32'd1);
        chk("pk4 s2 data", c_data, 32'h51);
        drive(0, 0, 1, 32'h55, 1, 1);
        chk("pk4 s3 valid", 32'(c_valid), 32'd0);
        chk("pk4 s3 level", 32'(c_level), 32'd3);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 32'h0, 0, 1);
            chk($sformatf("pk4 rd%0d valid", k), 32'(c_valid), 32'd1);
            chk($sformatf("pk4 rd%0d data", k), c_data, 32'h52 + 32'(k));
            chk($sformatf("pk4 rd%0d last", k), 32'(c_last), 32'(k == 3));
            chk($sformatf("pk4 rd%0d pkt", k), 32'(c_pkt), 32'd1);
        end
        drive(0, 0, 0, 32'h0, 0, 0);
        chk("pk4 end valid", 32'(c_valid), 32'd0);
        chk("pk4 end pkt", 32'(c_pkt), 32'd0);

        // Flush with three entries stored.
        drive(0, 1, 0, 32'h0, 0, 0);
        drive(0, 0, 1, 32'h60, 1, 0);
        drive(0, 0, 1, 32'h61, 0, 0);
        drive(0, 0, 1, 32'h62, 0, 0);
        drive(0, 1, 1, 32'h63, 0, 1);
        chk("flush ready", 32'(a_ready), 32'd0);
        chk("flush valid", 32'(a_valid), 32'd0);
        chk("flush level", 32'(a_level), 32'd3);
        chk("flush pkt", 32'(a_pkt), 32'd1);
        drive(0, 0, 0, 32'h0, 0, 0);
        chk("post flush level", 32'(a_level), 32'd0);
        chk("post flush pkt", 32'(a_pkt), 32'd0);
        chk("post flush valid", 32'(a_valid), 32'd0);
        chk("post flush ready", 32'(a_ready), 32'd1);

        // Reset mid-stream with valid_i held high.
        drive(0, 0, 1, 32'h70, 1, 0);
        drive(0, 0, 1, 32'h71, 0, 0);
        drive(1, 0, 1, 32'h72, 1, 1);
        chk("mid rst ready", 32'(a_ready), 32'd0);
        chk("mid rst valid", 32'(a_valid), 32'd0);
        chk("mid rst level", 32'(a_level), 32'd0);
        chk("mid rst aempty", 32'(a_ae), 32'd1);
        drive(1, 0, 1, 32'h73, 1, 1);
        chk("mid rst2 valid", 32'(a_valid), 32'd0);
        drive(0, 0, 0, 32'h0, 0, 0);
        chk("after rst level", 32'(a_level), 32'd0);
        chk("after rst pkt", 32'(a_pkt), 32'd0);
        chk("after rst valid", 32'(a_valid), 32'd0);
        drive(0, 0, 1, 32'h80, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0);
        chk("after rst first valid", 32'(a_valid), 32'd1);
        chk("after rst first data", a_data, 32'h80);
        chk("after rst first level", 32'(a_level), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
